// File: rtl/instrmem_loader.sv
// ---------------------------------------------------------------------------
// instrmem_loader
//
// Boot-time program loader for the instruction memory. Bytes arriving on a
// valid/ready stream are packed big-endian into 32-bit words (first byte of a
// word lands in [31:24], which is what the fetch side reads at the lowest
// address) and written out with byte strobes, starting at BASE_ADDR and
// advancing one word per write. A short final word is padded with 0x00 in the
// unfilled lanes and those lanes have their strobes cleared.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start, len_in    one-cycle load request and image length in bytes
//                    (sampled only while idle)
//   byte_in,
//   byte_valid,
//   byte_ready       input byte stream; a byte moves when valid && ready
//   wr_en            one-cycle instruction memory write strobe
//   wr_addr          word-aligned byte address of the write
//   wr_data          packed word, [31:24] -> wr_addr+0 ... [7:0] -> wr_addr+3
//   wr_strb          byte enables, wr_strb[3] covers wr_data[31:24]
//   busy             load in progress (including the done cycle)
//   done             one-cycle pulse when the load has finished
//   error            last start was rejected (zero or oversized length);
//                    held until the next start or reset
// ---------------------------------------------------------------------------
module instrmem_loader #(
    parameter int unsigned        A_WIDTH   = 32,
    parameter int unsigned        D_WIDTH   = 8,
    parameter logic [A_WIDTH-1:0] BASE_ADDR = 32'hBFC00000,
    parameter int unsigned        MAX_BYTES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] len_in,
    input  logic [D_WIDTH-1:0] byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               wr_en,
    output logic [A_WIDTH-1:0] wr_addr,
    output logic [31:0]        wr_data,
    output logic [3:0]         wr_strb,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [A_WIDTH-1:0] MAX_LEN   = A_WIDTH'(MAX_BYTES);
    localparam logic [A_WIDTH-1:0] ONE       = A_WIDTH'(1);
    localparam logic [A_WIDTH-1:0] WORD_STEP = A_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Control state (reset)
    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               wr_en_q, wr_en_d;
    logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic [3:0]         wr_strb_q, wr_strb_d;

    // Datapath state (initialised on every accepted start, no reset needed)
    logic [A_WIDTH-1:0] len_q, len_d;
    logic [A_WIDTH-1:0] count_q, count_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]        pack_q, pack_d;
    logic [3:0]         mask_q, mask_d;

    // Combinational helpers
    logic               hs;
    logic [1:0]         lane_sel;
    logic [31:0]        pack_next;
    logic [3:0]         mask_next;
    logic               last_byte;
    logic               word_full;

    // Drop a byte into its lane; lane 0 is the most significant byte.
    function automatic logic [31:0] insert_lane(input logic [31:0]        word,
                                                input logic [1:0]         lane,
                                                input logic [D_WIDTH-1:0] b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    // Strobe bit for a lane; strobe bit 3 belongs to lane 0.
    function automatic logic [3:0] lane_strobe(input logic [1:0] lane);
        return 4'b1000 >> lane;
    endfunction

    always_comb begin
        // handshake is qualified by the registered ready, so byte_valid never
        // feeds back into byte_ready within a cycle
        hs        = byte_valid && ready_q;
        lane_sel  = count_q[1:0];
        pack_next = insert_lane(pack_q, lane_sel, byte_in);
        mask_next = mask_q | lane_strobe(lane_sel);
        last_byte = ((count_q + ONE) == len_q);
        word_full = (lane_sel == 2'd3);

        state_d   = state_q;
        error_d   = error_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;
        len_d     = len_q;
        count_d   = count_q;
        addr_d    = addr_q;
        pack_d    = pack_q;
        mask_d    = mask_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((len_in == '0) || (len_in > MAX_LEN)) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        len_d   = len_in;
                        count_d = '0;
                        addr_d  = BASE_ADDR;
                        pack_d  = '0;
                        mask_d  = '0;
                        state_d = S_RECV;
                    end
                end
            end

            S_RECV: begin
                if (hs) begin
                    count_d = count_q + ONE;
                    if (word_full || last_byte) begin
                        // emit the completed word next cycle; the pack register
                        // restarts empty so a byte in the write cycle opens
                        // the next word without a bubble
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = pack_next;
                        wr_strb_d = mask_next;
                        addr_d    = addr_q + WORD_STEP;
                        pack_d    = '0;
                        mask_d    = '0;
                    end else begin
                        pack_d = pack_next;
                        mask_d = mask_next;
                    end
                    if (last_byte) begin
                        state_d = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                // final write is on the bus during this state
                state_d = S_DONE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_RECV);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q   <= len_d;
        count_q <= count_d;
        addr_q  <= addr_d;
        pack_q  <= pack_d;
        mask_q  <= mask_d;
    end

    assign byte_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_strb    = wr_strb_q;

endmodule

// File: doc/instrmem_loader.md
# instrmem_loader

Program loader that writes the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit words in the same byte order the fetch side reads (lowest address = bits [31:24]), and issues word writes with byte strobes starting at the reset-vector base. It sits between the host/boot byte source and the instruction memory write port, and runs before the core is released from reset.

## Interface
- A_WIDTH, 32, address width of the instruction memory
- D_WIDTH, 8, width of one stream element (one memory byte)
- BASE_ADDR, 32'hBFC00000, byte address of the first write
- MAX_BYTES, 4096, largest accepted image length in bytes

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- len_in  in  A_WIDTH  image length in bytes; sampled with start
- byte_in  in  D_WIDTH  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  one-cycle write strobe to instruction memory
- wr_addr  out  A_WIDTH  word-aligned byte address of the write
- wr_data  out  32  packed word; [31:24] goes to wr_addr+0, [7:0] to wr_addr+3
- wr_strb  out  4  byte enables; wr_strb[3] covers wr_data[31:24]
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load complete
- error  out  1  last start rejected; sticky until next start or rst

## Operation
- States: IDLE, RECV, FLUSH, DONE.
- IDLE: byte_ready=0, busy=0. On start: len_in==0 or len_in>MAX_BYTES -> error=1, stay IDLE. Otherwise error=0, latch len, count=0, word address=BASE_ADDR, clear pack register and lane mask, go RECV.
- RECV: byte_ready=1, busy=1. Handshake = byte_valid && byte_ready. Each handshake writes byte_in into lane count[1:0] (lane 0 -> [31:24], lane 3 -> [7:0]), sets that lane's strobe bit, count increments.
- Word completes on the handshake where count[1:0]==3 or count+1==len. Next cycle: wr_en=1 with wr_addr/wr_data/wr_strb from the completed word; word address += 4; pack register and mask cleared. Unfilled lanes carry 0x00 and strobe 0.
- Stream stays open while the write is issued: a handshake in the wr_en cycle starts the next word (no bubble required).
- Handshake of the last byte (count+1==len) -> FLUSH (byte_ready=0). FLUSH drives the final write, then DONE.
- DONE: done=1, busy=1 for one cycle, then IDLE. error stays 0.
- start outside IDLE ignored. byte_valid outside RECV ignored (ready low, no bytes consumed).
- Counter and address widths A_WIDTH; no wrap is possible since len<=MAX_BYTES and BASE_ADDR+MAX_BYTES fits in A_WIDTH.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, wr_strb=0, busy=0, done=0, error=0, state IDLE.
- start accepted at edge k -> byte_ready=1 from cycle k+1.
- Word write latency: wr_en high exactly one cycle after the completing handshake.
- Last byte at edge n -> final wr_en in cycle n+1 (FLUSH), done in cycle n+2, IDLE (busy=0) in cycle n+3.
- Back-to-back valid bytes: N bytes complete in N handshake cycles + 2.
- rst mid-load: returns to IDLE next edge; partial word discarded, no wr_en issued, done not pulsed.
- All outputs registered; no combinational path from byte_valid to byte_ready.

## Test plan
- start, len_in=8, bytes 0x11..0x88 back-to-back -> wr_en at BFC00000 data 0x11223344 strb 4'hF, then BFC00004 data 0x55667788 strb 4'hF; done pulse 2 cycles after last byte.
- len_in=6, bytes 0xA1..0xA6 -> writes 0xA1A2A3A4 strb F at BFC00000, 0xA5A60000 strb 4'b1100 at BFC00004; done follows.
- len_in=0, then len_in=4097 -> error=1 each time, byte_ready stays 0, no wr_en; following start with len_in=4 clears error.
- len_in=4 with byte_valid gapped (valid every 3rd cycle) -> single write 4 bytes in stream order, only valid cycles consumed.
- start again while busy, and byte_valid while IDLE -> both ignored, no state or count change.
- rst asserted after 3 of 8 bytes -> no wr_en, busy=0 next cycle; fresh start with len_in=4 writes BFC00000 correctly.
